// File: rtl/ddr3_phy_pkg.sv
// Shared definitions for the DDR3 PHY IOD delay-line control logic:
// FSM state encoding, default timing limits and the lane packing helper.
package ddr3_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_MOVE   = 3'd2,
        ST_GAP    = 3'd3,
        ST_LOAD   = 3'd4,
        ST_FINISH = 3'd5,
        ST_FAIL   = 3'd6
    } dly_state_t;

    localparam int DEF_MAX_TAP  = 127;
    localparam int DEF_MOVE_GAP = 3;

    // Bit offset of a lane inside the packed shadow-tap bus.
    function automatic int lane_offset(input int lane, input int tap_w);
        return lane * tap_w;
    endfunction

endpackage

// File: rtl/ddr3_iod_delay_ctrl_if.sv
// Request/completion bus between the PHY training sequencer (master)
// and the IOD delay controller (slave).
interface ddr3_iod_delay_ctrl_if #(
    parameter int LANE_W = 2,
    parameter int TAP_W  = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic [LANE_W-1:0] req_lane;
    logic [TAP_W-1:0]  req_tap;
    logic              req_load;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_lane, req_tap, req_load,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_lane, req_tap, req_load,
        output req_ready, done, err
    );

endinterface

// File: rtl/ddr3_iod_lane_strobe.sv
// Per-lane IOD driver: registered MOVE/LOAD/DIRECTION strobes decoded from
// the controller's next-state commands, plus the lane's shadow tap register.
module ddr3_iod_lane_strobe #(
    parameter int TAP_W       = 8,
    parameter int DEFAULT_TAP = 1
) (
    input  logic             fab_clk,
    input  logic             arst_n,
    input  logic             sel_next,
    input  logic             sel,
    input  logic             move_next,
    input  logic             load_next,
    input  logic             dir_set,
    input  logic             dir_val,
    input  logic             tap_inc,
    input  logic             tap_dec,
    input  logic             tap_load,
    output logic             move,
    output logic             load,
    output logic             dir,
    output logic [TAP_W-1:0] tap
);

    localparam logic [TAP_W-1:0] TAP_DEFAULT = TAP_W'(DEFAULT_TAP);

    logic             move_reg;
    logic             load_reg;
    logic             dir_reg;
    logic [TAP_W-1:0] tap_reg;

    // Strobes are registered from the next state so they line up exactly
    // with the cycle the FSM spends in MOVE or LOAD.
    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            move_reg <= 1'b0;
            load_reg <= 1'b0;
            dir_reg  <= 1'b0;
            tap_reg  <= TAP_DEFAULT;
        end else begin
            move_reg <= sel_next & move_next;
            load_reg <= sel_next & load_next;
            if (sel_next && dir_set) begin
                dir_reg <= dir_val;
            end
            if (sel) begin
                if (tap_load) begin
                    tap_reg <= TAP_DEFAULT;
                end else if (tap_inc) begin
                    tap_reg <= tap_reg + 1'b1;
                end else if (tap_dec) begin
                    tap_reg <= tap_reg - 1'b1;
                end
            end
        end
    end

    assign move = move_reg;
    assign load = load_reg;
    assign dir  = dir_reg;
    assign tap  = tap_reg;

endmodule

// File: rtl/ddr3_iod_delay_ctrl.sv
// Delay-line tap controller for a group of DDR3 IOD lanes: turns "set lane L
// to tap T" requests into spaced MOVE/DIRECTION/LOAD sequences on one lane.
module ddr3_iod_delay_ctrl
    import ddr3_phy_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int LANE_W      = 2,
    parameter int TAP_W       = 8,
    parameter int MAX_TAP     = DEF_MAX_TAP,
    parameter int DEFAULT_TAP = 1,
    parameter int MOVE_GAP    = DEF_MOVE_GAP
) (
    input  logic                       fab_clk,
    input  logic                       arst_n,
    ddr3_iod_delay_ctrl_if.slave       req_if,
    output logic [NUM_LANES-1:0]       delay_line_move,
    output logic [NUM_LANES-1:0]       delay_line_direction,
    output logic [NUM_LANES-1:0]       delay_line_load,
    input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
    output logic [NUM_LANES*TAP_W-1:0] cur_tap
);

    localparam int GAP_W = (MOVE_GAP < 2) ? 1 : $clog2(MOVE_GAP);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(MOVE_GAP - 1);
    localparam logic [LANE_W:0]   LANE_LIMIT = (LANE_W + 1)'(NUM_LANES);
    localparam logic [TAP_W-1:0]  TAP_MAX    = TAP_W'(MAX_TAP);

    dly_state_t         state_reg,   state_next;
    logic [LANE_W-1:0]  lane_reg,    lane_next;
    logic [TAP_W-1:0]   target_reg,  target_next;
    logic               up_reg,      up_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               done_reg;
    logic               err_reg;

    logic [TAP_W-1:0]   tap_arr [NUM_LANES];
    logic [TAP_W-1:0]   act_tap;
    logic [TAP_W-1:0]   req_cur_tap;
    logic               act_oor;
    logic               req_illegal;

    // Lane muxes written as compare loops so an out-of-range lane index
    // simply selects nothing instead of indexing past the array.
    always_comb begin
        act_tap     = '0;
        req_cur_tap = '0;
        act_oor     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_reg == LANE_W'(i)) begin
                act_tap = tap_arr[i];
                act_oor = delay_line_out_of_range[i];
            end
            if (req_if.req_lane == LANE_W'(i)) begin
                req_cur_tap = tap_arr[i];
            end
        end
    end

    assign req_illegal = ({1'b0, req_if.req_lane} >= LANE_LIMIT) ||
                         (!req_if.req_load && (req_if.req_tap > TAP_MAX));

    always_comb begin
        state_next   = state_reg;
        lane_next    = lane_reg;
        target_next  = target_reg;
        up_next      = up_reg;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    lane_next   = req_if.req_lane;
                    target_next = req_if.req_tap;
                    up_next     = req_if.req_tap > req_cur_tap;
                    if (req_illegal) begin
                        state_next = ST_FAIL;
                    end else if (req_if.req_load) begin
                        state_next = ST_LOAD;
                    end else if (req_if.req_tap == req_cur_tap) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: state_next = ST_MOVE;
            ST_MOVE: begin
                state_next   = ST_GAP;
                gap_cnt_next = '0;
            end
            ST_GAP: begin
                if (act_oor) begin
                    state_next = ST_FAIL;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next = (act_tap != target_reg) ? ST_MOVE : ST_FINISH;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            ST_LOAD:   state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            ST_FAIL:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= ST_IDLE;
            lane_reg    <= '0;
            target_reg  <= '0;
            up_reg      <= 1'b0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lane_reg    <= lane_next;
            target_reg  <= target_next;
            up_reg      <= up_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= (state_next == ST_FINISH);
            err_reg     <= (state_next == ST_FAIL);
        end
    end

    // An out-of-range flag in GAP reverses the step taken in the preceding MOVE.
    logic tap_inc, tap_dec, tap_load;
    assign tap_inc  = ((state_reg == ST_MOVE) &&  up_reg) ||
                      ((state_reg == ST_GAP) && act_oor && !up_reg);
    assign tap_dec  = ((state_reg == ST_MOVE) && !up_reg) ||
                      ((state_reg == ST_GAP) && act_oor &&  up_reg);
    assign tap_load = (state_reg == ST_LOAD);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        ddr3_iod_lane_strobe #(
            .TAP_W       (TAP_W),
            .DEFAULT_TAP (DEFAULT_TAP)
        ) u_lane (
            .fab_clk   (fab_clk),
            .arst_n    (arst_n),
            .sel_next  (lane_next == LANE_W'(gi)),
            .sel       (lane_reg == LANE_W'(gi)),
            .move_next (state_next == ST_MOVE),
            .load_next (state_next == ST_LOAD),
            .dir_set   (state_next == ST_SETUP),
            .dir_val   (up_next),
            .tap_inc   (tap_inc),
            .tap_dec   (tap_dec),
            .tap_load  (tap_load),
            .move      (delay_line_move[gi]),
            .load      (delay_line_load[gi]),
            .dir       (delay_line_direction[gi]),
            .tap       (tap_arr[gi])
        );
        assign cur_tap[lane_offset(gi, TAP_W) +: TAP_W] = tap_arr[gi];
    end

    assign req_if.req_ready = (state_reg == ST_IDLE);
    assign req_if.done      = done_reg;
    assign req_if.err       = err_reg;

endmodule

// File: tb/tb_ddr3_iod_delay_ctrl.sv
// Self-checking bench for ddr3_iod_delay_ctrl: directed plan plus random
// requests against a transaction-level tap model.
module tb_ddr3_iod_delay_ctrl;

    localparam int G    = 3;
    localparam int MAXT = 127;
    localparam int DEFT = 1;

    logic        clk;
    logic        arst_n;
    logic [3:0]  move, dir, ld, oor;
    logic [31:0] cur_tap;
    logic [2:0]  move_s, dir_s, ld_s;
    logic [2:0]  oor_s;
    logic [23:0] cur_tap_s;

    int total = 0;
    int bad   = 0;
    int model_tap [4];

    ddr3_iod_delay_ctrl_if #(.LANE_W(2), .TAP_W(8)) bus ();
    ddr3_iod_delay_ctrl_if #(.LANE_W(2), .TAP_W(8)) bus_s ();

    ddr3_iod_delay_ctrl dut (
        .fab_clk                 (clk),
        .arst_n                  (arst_n),
        .req_if                  (bus),
        .delay_line_move         (move),
        .delay_line_direction    (dir),
        .delay_line_load         (ld),
        .delay_line_out_of_range (oor),
        .cur_tap                 (cur_tap)
    );

    // Three-lane instance: the only way a 2-bit lane index can be illegal.
    ddr3_iod_delay_ctrl #(.NUM_LANES(3), .LANE_W(2)) dut_s (
        .fab_clk                 (clk),
        .arst_n                  (arst_n),
        .req_if                  (bus_s),
        .delay_line_move         (move_s),
        .delay_line_direction    (dir_s),
        .delay_line_load         (ld_s),
        .delay_line_out_of_range (oor_s),
        .cur_tap                 (cur_tap_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_taps(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk(tag, int'(cur_tap[i*8 +: 8]), model_tap[i]);
        end
    endtask

    task automatic run_req(input int lane, input int tap, input bit ld_req,
                           input int oor_at, input int rst_at);
        int cur, n, up, exp_err, exp_moves, exp_loads, exp_end, exp_final;
        int mv, lds, other, end_k;
        bit got_done, got_err, inj, illegal, did_rst;
        cur     = model_tap[lane];
        illegal = !ld_req && (tap > MAXT);
        n       = (tap > cur) ? tap - cur : cur - tap;
        up      = (tap > cur) ? 1 : 0;
        exp_err = 0; exp_moves = 0; exp_loads = 0; exp_final = cur;
        if (illegal) begin
            exp_err = 1; exp_end = 1;
        end else if (ld_req) begin
            exp_loads = 1; exp_end = 2; exp_final = DEFT;
        end else if (oor_at > 0) begin
            exp_moves = oor_at; exp_err = 1;
            exp_end   = 2 + (oor_at - 1) * (G + 1) + 2;
            exp_final = up ? cur + oor_at - 1 : cur - oor_at + 1;
        end else begin
            exp_moves = n; exp_final = tap;
            exp_end   = (n == 0) ? 1 : 2 + n * (G + 1);
        end

        @(negedge clk);
        chk("ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_lane  = lane[1:0];
        bus.req_tap   = tap[7:0];
        bus.req_load  = ld_req;
        @(posedge clk);
        mv = 0; lds = 0; other = 0; end_k = 0;
        got_done = 0; got_err = 0; inj = 0; did_rst = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            oor       = 4'($urandom);
            oor[lane] = inj;
            for (int i = 0; i < 4; i++) begin
                if (i != lane && (move[i] || ld[i])) other++;
            end
            if (ld[lane]) lds++;
            if (k == 1 && !illegal && !ld_req && n > 0) chk("setup_dir", dir[lane], up);
            if (move[lane]) begin
                mv++;
                chk("move_cyc", k, 2 + (mv - 1) * (G + 1));
                chk("move_dir", dir[lane], up);
                if (oor_at > 0 && mv == oor_at) begin
                    inj       = 1'b1;
                    oor[lane] = 1'b1;
                end
                if (rst_at > 0 && mv == rst_at) begin
                    arst_n = 1'b0;
                    #1;
                    chk("rst_move", int'(move), 0);
                    chk("rst_load", int'(ld), 0);
                    chk("rst_ready", bus.req_ready, 1);
                    chk("rst_done", bus.done, 0);
                    for (int i = 0; i < 4; i++) model_tap[i] = DEFT;
                    chk_taps("rst_tap");
                    did_rst = 1;
                    break;
                end
            end
            if (bus.done || bus.err) begin
                got_done = bus.done;
                got_err  = bus.err;
                end_k    = k;
                break;
            end
        end
        oor = '0;
        if (did_rst) begin
            @(negedge clk);
            @(negedge clk);
            arst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("post_rst_idle", int'(bus.done | bus.err | (|move)), 0);
            end
            $display("req lane=%0d tap=%0d load=%0d reset after %0d moves", lane, tap, ld_req, mv);
            return;
        end
        chk("end_cyc", end_k, exp_end);
        chk("err", got_err, exp_err);
        chk("done", got_done, 1 - exp_err);
        chk("moves", mv, exp_moves);
        chk("loads", lds, exp_loads);
        chk("other_strobes", other, 0);
        model_tap[lane] = exp_final;
        chk_taps("tap");
        $display("req lane=%0d tap=%0d load=%0d oor_at=%0d end_cyc=%0d done=%0d err=%0d moves=%0d",
                 lane, tap, ld_req, oor_at, end_k, got_done, got_err, mv);
    endtask

    initial begin
        int lane, tap, n, oor_at;
        bit ld_req;
        arst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_lane = '0; bus.req_tap = '0; bus.req_load = 1'b0;
        bus_s.req_valid = 1'b0; bus_s.req_lane = '0; bus_s.req_tap = '0; bus_s.req_load = 1'b0;
        oor = '0; oor_s = '0;
        for (int i = 0; i < 4; i++) model_tap[i] = DEFT;
        #12;
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_move", int'(move), 0);
        chk("reset_load", int'(ld), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_done", bus.done, 0);
        chk("reset_err", bus.err, 0);
        chk_taps("reset_tap");
        @(negedge clk);
        arst_n = 1'b1;

        run_req(2, 5, 0, 0, 0);
        run_req(2, 3, 0, 0, 0);
        run_req(2, 3, 0, 0, 0);
        run_req(1, 40, 0, 0, 0);
        run_req(1, 0, 1, 0, 0);
        run_req(0, 200, 0, 0, 0);
        run_req(0, 10, 0, 3, 0);
        run_req(3, 9, 0, 0, 2);

        // Illegal lane on the three-lane instance.
        @(negedge clk);
        bus_s.req_valid = 1'b1; bus_s.req_lane = 2'd3; bus_s.req_tap = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus_s.req_valid = 1'b0;
        chk("s_err", bus_s.err, 1);
        chk("s_done", bus_s.done, 0);
        chk("s_strobes", int'(move_s | ld_s), 0);
        @(negedge clk);
        chk("s_err_pulse", bus_s.err, 0);
        chk("s_ready", bus_s.req_ready, 1);
        chk("s_strobes2", int'(move_s | ld_s), 0);
        chk("s_taps", int'(cur_tap_s), 32'h0001_0101);
        $display("req small lane=3 tap=5 -> err checked");

        for (int r = 0; r < 30; r++) begin
            lane   = $urandom_range(0, 3);
            tap    = $urandom_range(0, 140);
            ld_req = ($urandom_range(0, 7) == 0);
            oor_at = 0;
            n = (tap > model_tap[lane]) ? tap - model_tap[lane] : model_tap[lane] - tap;
            if (!ld_req && tap <= MAXT && n > 0 && $urandom_range(0, 4) == 0)
                oor_at = $urandom_range(1, n);
            run_req(lane, tap, ld_req, oor_at, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_iod_delay_ctrl.md
Name: ddr3_iod_delay_ctrl

Overview:
- Parametrised delay-line tap controller for a group of DDR3 PHY IOD lanes (address/command or DQ).
- Converts "set lane L to tap T" requests into correctly spaced DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD sequences on each IOD.
- Keeps a shadow copy of every lane's current tap and handles the IOD out-of-range flag.
- Sits between the PHY training sequencer and the per-lane IOD wrappers, replacing hand-driven per-lane delay pins.

Parameters:
- NUM_LANES, 4: number of IOD lanes controlled (1..32).
- LANE_W, 2: lane index width, equal to max(1, clog2(NUM_LANES)).
- TAP_W, 8: tap counter width.
- MAX_TAP, 127: highest legal tap value (must be less than 2^TAP_W).
- DEFAULT_TAP, 1: tap the IOD returns to on LOAD; must match the IOD TX/RX_DELAY_VAL.
- MOVE_GAP, 3: idle cycles required after each MOVE pulse before the next MOVE (at least 1).

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- ARST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  controller idle; a request is accepted on the cycle where VALID and READY are both high.
- REQ_LANE  in  LANE_W  target lane index.
- REQ_TAP  in  TAP_W  target tap value.
- REQ_LOAD  in  1  1 = reload the lane to DEFAULT_TAP (REQ_TAP is ignored).
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move strobe per lane.
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment, 0 = decrement.
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load strobe per lane.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  out-of-range flags from the IODs.
- CUR_TAP  out  NUM_LANES*TAP_W  shadow taps; lane i occupies bits [i*TAP_W +: TAP_W].
- DONE  out  1  one-cycle pulse when a request completes.
- ERR  out  1  one-cycle pulse when a request is rejected or aborted.

Behaviour:
- Reset values while ARST_N is low, applied asynchronously:
  - FSM is IDLE and REQ_READY = 1.
  - MOVE, LOAD and DIRECTION are all 0.
  - DONE = 0 and ERR = 0.
  - Every CUR_TAP lane = DEFAULT_TAP.
  - Reset during a request abandons it with no DONE or ERR; the IOD lanes are reset by the same ARST_N.
- FSM states: IDLE, SETUP, MOVE, GAP, LOAD, FINISH, FAIL.
- IDLE: REQ_READY = 1. On acceptance the lane, target and load flag are latched. Then:
  - REQ_LANE >= NUM_LANES, or REQ_TAP > MAX_TAP without REQ_LOAD: go to FAIL. No strobes are issued and CUR_TAP is unchanged.
  - REQ_LOAD: go to LOAD.
  - Target equals CUR_TAP[lane]: go to FINISH (zero moves).
  - Otherwise: go to SETUP.
- LOAD (1 cycle): DELAY_LINE_LOAD[lane] = 1 and CUR_TAP[lane] is set to DEFAULT_TAP. Then FINISH.
- SETUP (1 cycle): DIRECTION[lane] = (target > CUR_TAP[lane]). DIRECTION is held stable from SETUP through the last GAP cycle, so it is valid one cycle before the first MOVE.
- MOVE (1 cycle): MOVE[lane] = 1, and CUR_TAP[lane] steps by +1 or -1 at the end of the cycle. Then GAP.
- GAP: lasts MOVE_GAP cycles. During GAP, DELAY_LINE_OUT_OF_RANGE[lane] is sampled every cycle:
  - If the flag is high: undo the last step on CUR_TAP[lane] and go to FAIL.
  - At the end of GAP: go to MOVE if CUR_TAP differs from the target, otherwise go to FINISH.
- FINISH: DONE = 1 for 1 cycle, then IDLE.
- FAIL: ERR = 1 for 1 cycle, then IDLE.
- Latency, with acceptance in cycle 0:
  - n moves: DONE in cycle 2 + n*(1+MOVE_GAP).
  - Load: DONE in cycle 2.
  - Zero moves: DONE in cycle 1.
- Non-selected lanes: strobes stay 0 and DIRECTION keeps its last value.
- Only one lane moves at a time; REQ_READY = 0 everywhere outside IDLE.
- Tap arithmetic is unsigned TAP_W. Overflow cannot occur because the target is checked against MAX_TAP first.
- The out-of-range flag is ignored outside GAP and on lanes that are not active.

Decomposition:
- Shared package ddr3_phy_pkg holds:
  - the FSM state enum;
  - the lane-offset helper, i*TAP_W;
  - the default values of MAX_TAP and MOVE_GAP.
- Sub-module ddr3_iod_lane_strobe (one instance per lane): decodes the FSM output into that lane's registered MOVE, LOAD and DIRECTION and holds its tap register.

Test Plan (defaults, MOVE_GAP = 3, DEFAULT_TAP = 1):
- Increment: reset, then request lane 2, tap 5 -> DIRECTION[2] = 1; 4 MOVE pulses spaced 4 cycles apart; DONE in cycle 18; CUR_TAP[2] = 5.
- Decrement and zero-move: request lane 2, tap 3 after the previous test -> 2 pulses with DIRECTION[2] = 0 and CUR_TAP[2] = 3. Repeat lane 2, tap 3 -> DONE in cycle 1 with no strobes.
- Load: with lane 1 at 40, request REQ_LOAD on lane 1 -> a single LOAD[1] pulse, CUR_TAP[1] = 1, DONE in cycle 2.
- Illegal requests: lane 4 -> ERR and no strobes. Lane 0, tap 200 -> ERR, CUR_TAP unchanged.
- Out-of-range: request lane 0, tap 10, and force OUT_OF_RANGE[0] high in the GAP after the 3rd MOVE -> ERR, CUR_TAP[0] = 3, no 4th MOVE.
- Reset mid-operation: assert ARST_N low after the 2nd MOVE of a lane 3 to tap 9 request -> all strobes drop immediately, every CUR_TAP = 1, REQ_READY = 1, no DONE.
